// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: frame constants, FSM state encoding and parity helper.
package uart_pkg;

  localparam int unsigned CYCLES_PER_BIT_DEF = 14;
  localparam int unsigned DATA_BITS          = 8;
  localparam logic        START_LVL          = 1'b0;
  localparam logic        STOP_LVL           = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } tx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; read data is the head entry combinationally, count updates the edge after push/pop.
// Push while full and pop while empty are ignored, so the producer simply holds its data until !full.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: start, 8 data MSB-first, even parity, stop; tx low 2 cycles after an accept into an idle block.
// tx_ready = !full of the byte FIFO; UART_TX_TWO_STOP_EN selects a two-bit-time stop.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = CYCLES_PER_BIT_DEF,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned IDLE_GAP_BITS  = 1
) (
  input  logic                          clk_3125,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

`ifdef UART_TX_TWO_STOP_EN
  localparam int unsigned STOP_CYC = 2 * CYCLES_PER_BIT;
`else
  localparam int unsigned STOP_CYC = CYCLES_PER_BIT;
`endif
  localparam int unsigned GAP_CYC = IDLE_GAP_BITS * CYCLES_PER_BIT;
  localparam int unsigned CW      = 16;

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            busy_q, stop_end_q, done_q;
  logic            last_stop, load, fifo_empty, fifo_full;
  logic [7:0]      fifo_rdata;
  logic            bit_last, stop_last, gap_last;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_i   (clk_3125),
    .rst_ni  (rst_n),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (load),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tx_ready  = !fifo_full;
  assign bit_last  = (cnt_q == CW'(CYCLES_PER_BIT - 1));
  assign stop_last = (cnt_q == CW'(STOP_CYC - 1));
  assign gap_last  = (cnt_q == CW'(GAP_CYC - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    last_stop = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        load  = !fifo_empty;
      end
      S_START: if (bit_last) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (bit_last) begin
        cnt_d   = '0;
        shift_d = {shift_q[6:0], 1'b0};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'(DATA_BITS - 1)) state_d = S_PARITY;
      end
      S_PARITY: if (bit_last) begin
        cnt_d   = '0;
        state_d = S_STOP;
      end
      // The next byte is loaded on the final spacing cycle so the frame period has no extra idle cycle.
      S_STOP: if (stop_last) begin
        last_stop = 1'b1;
        cnt_d     = '0;
        if (GAP_CYC > 0) begin
          state_d = S_GAP;
        end else begin
          state_d = S_IDLE;
          load    = !fifo_empty;
        end
      end
      S_GAP: if (gap_last) begin
        cnt_d   = '0;
        state_d = S_IDLE;
        load    = !fifo_empty;
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      shift_d = fifo_rdata;
      par_d   = even_parity(fifo_rdata);
      cnt_d   = '0;
      state_d = S_START;
    end
  end

  // Line level follows the state one cycle later, so tx only moves at bit boundaries.
  always_comb begin
    tx_d = STOP_LVL;
    case (state_q)
      S_START:  tx_d = START_LVL;
      S_DATA:   tx_d = shift_q[7];
      S_PARITY: tx_d = par_q;
      default:  tx_d = STOP_LVL;
    endcase
  end

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= STOP_LVL;
      busy_q     <= 1'b0;
      stop_end_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= (state_q != S_IDLE);
      stop_end_q <= last_stop;
      done_q     <= stop_end_q;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: frame shape, timing, burst backpressure, reset mid-frame, receiver loopback.
module tb_uart_tx_buffered;

  localparam int CPB = 14;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NB      = 12;
  localparam int SPACING = 182;
`else
  localparam int NB      = 11;
  localparam int SPACING = 168;
`endif
  localparam int FRAME = NB * CPB;
  localparam int BOUND = 4000;

  logic       clk_3125 = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, tx_busy, tx_done;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk_3125 = ~clk_3125;
  always @(posedge clk_3125) cyc <= cyc + 1;

  uart_tx_buffered dut (
    .clk_3125   (clk_3125),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic push(input logic [7:0] d, output int acc);
    int w;
    w = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && w < BOUND) begin
      @(negedge clk_3125);
      w++;
    end
    @(negedge clk_3125);
    acc = cyc;
    tx_valid = 1'b0;
    checks++;
    if (w >= BOUND) begin errors++; $display("FAIL push_timeout data %h never accepted", d); end
  endtask

  // Records the line value of each bit-time from the first low sample; counts tx_done pulses.
  task automatic capture(output logic [11:0] bits, output int s, output int unstable,
                         output int done_at, output int done_cnt);
    int w;
    bits = '1; s = -1; unstable = 0; done_at = -1; done_cnt = 0; w = 0;
    while (tx !== 1'b0 && w < BOUND) begin
      @(negedge clk_3125);
      w++;
    end
    if (tx !== 1'b0) return;
    s = cyc;
    for (int c = 0; c < FRAME + 2; c++) begin
      if (c > 0) @(negedge clk_3125);
      if (c < FRAME) begin
        if (c % CPB == 0) bits[c / CPB] = tx;
        else if (tx !== bits[c / CPB]) unstable++;
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc - s;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk_3125);
    checks++; if (tx !== 1'b1)         begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    checks++; if (tx_done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    checks++; if (tx_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b want 1", tx_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_3125);
  endtask

  task automatic test_frame(input logic [7:0] d, input logic [11:0] exp);
    int n, s, un, da, dc;
    logic [11:0] b;
    push(d, n);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL frame_%h_count_at_accept got %0d want 1", d, fifo_count); end
    @(negedge clk_3125);
    checks++; if (fifo_count !== 3'd0 || tx !== 1'b1) begin
      errors++; $display("FAIL frame_%h_pop got count %0d tx %b want count 0 tx 1", d, fifo_count, tx); end
    capture(b, s, un, da, dc);
    checks++; if (s - n != 2)  begin errors++; $display("FAIL frame_%h_latency got %0d want 2", d, s - n); end
    checks++; if (b !== exp)   begin errors++; $display("FAIL frame_%h_bits got %h want %h", d, b, exp); end
    checks++; if (un != 0)     begin errors++; $display("FAIL frame_%h_bit_period unstable samples %0d want 0", d, un); end
    checks++; if (da != FRAME || dc != 1) begin
      errors++; $display("FAIL frame_%h_done got at %0d count %0d want at %0d count 1", d, da, dc, FRAME); end
    repeat (20) @(negedge clk_3125);
  endtask

  task automatic test_burst;
    int s[6];
    logic [7:0] got[6];
    int saw_full = 0;
    int un_sum = 0;
    fork
      begin
        int w;
        logic [7:0] v;
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
          v = 8'h11 + 8'(i);
          tx_data = v;
          w = 0;
          while (!tx_ready && w < BOUND) begin
            if (fifo_count == 3'd4) saw_full++;
            @(negedge clk_3125);
            w++;
          end
          @(negedge clk_3125);
        end
        tx_valid = 1'b0;
      end
      begin
        logic [11:0] b;
        int un, da, dc;
        for (int f = 0; f < 6; f++) begin
          capture(b, s[f], un, da, dc);
          un_sum += un;
          for (int j = 0; j < 8; j++) got[f][7-j] = b[1+j];
        end
      end
    join
    checks++; if (saw_full == 0) begin errors++; $display("FAIL burst_backpressure never saw tx_ready low with 4 queued"); end
    checks++; if (un_sum != 0)   begin errors++; $display("FAIL burst_bit_period unstable samples %0d want 0", un_sum); end
    for (int f = 0; f < 6; f++) begin
      checks++; if (got[f] !== 8'h11 + 8'(f)) begin
        errors++; $display("FAIL burst_order frame %0d got %h want %h", f, got[f], 8'h11 + 8'(f)); end
    end
    for (int f = 1; f < 6; f++) begin
      checks++; if (s[f] - s[f-1] != SPACING) begin
        errors++; $display("FAIL burst_spacing frame %0d got %0d want %0d", f, s[f] - s[f-1], SPACING); end
    end
    repeat (40) @(negedge clk_3125);
  endtask

  task automatic test_reset_mid;
    int n, w, bad_tx, bad_done, bad_cnt;
    push(8'h3C, n);
    push(8'h41, n);
    push(8'h42, n);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rstmid_queued got %0d want 2", fifo_count); end
    w = 0;
    while (tx !== 1'b0 && w < BOUND) begin @(negedge clk_3125); w++; end
    repeat (CPB + 3) @(negedge clk_3125);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx got %b want 0 (data bit 7 of 3C)", tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)         begin errors++; $display("FAIL rstmid_tx got %b want 1", tx); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", fifo_count); end
    checks++; if (tx_ready !== 1'b1)   begin errors++; $display("FAIL rstmid_ready got %b want 1", tx_ready); end
    checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got %b want 0", tx_busy); end
    repeat (2) @(negedge clk_3125);
    rst_n = 1'b1;
    bad_tx = 0; bad_done = 0; bad_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_3125);
      if (tx !== 1'b1) bad_tx++;
      if (tx_done !== 1'b0) bad_done++;
      if (fifo_count !== 3'd0) bad_cnt++;
    end
    checks++; if (bad_tx != 0)   begin errors++; $display("FAIL rstmid_line_idle low samples %0d want 0", bad_tx); end
    checks++; if (bad_done != 0) begin errors++; $display("FAIL rstmid_no_done pulses %0d want 0", bad_done); end
    checks++; if (bad_cnt != 0)  begin errors++; $display("FAIL rstmid_flushed nonzero count samples %0d want 0", bad_cnt); end
  endtask

  // Independent mid-bit sampling receiver.
  task automatic rx_byte(output logic [7:0] d, output logic perr, output logic ferr, output logic tmo);
    int w;
    logic p;
    d = 8'h00; perr = 1'b0; ferr = 1'b0; tmo = 1'b0; w = 0;
    while (tx !== 1'b0 && w < BOUND) begin @(negedge clk_3125); w++; end
    if (tx !== 1'b0) begin tmo = 1'b1; return; end
    repeat (CPB / 2) @(negedge clk_3125);
    if (tx !== 1'b0) ferr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk_3125);
      d[7-i] = tx;
    end
    repeat (CPB) @(negedge clk_3125);
    p = tx;
    if (p !== ^d) perr = 1'b1;
    repeat (CPB) @(negedge clk_3125);
    if (tx !== 1'b1) ferr = 1'b1;
  endtask

  task automatic test_loopback;
    logic [7:0] exp[3];
    logic [7:0] got[3];
    logic pe[3], fe[3], to[3];
    exp[0] = 8'h3C; exp[1] = 8'hFF; exp[2] = 8'h00;
    fork
      begin
        int n;
        for (int i = 0; i < 3; i++) push(exp[i], n);
      end
      begin
        for (int i = 0; i < 3; i++) rx_byte(got[i], pe[i], fe[i], to[i]);
      end
    join
    for (int i = 0; i < 3; i++) begin
      checks++; if (to[i] !== 1'b0 || got[i] !== exp[i]) begin
        errors++; $display("FAIL loopback_byte %0d got %h timeout %b want %h", i, got[i], to[i], exp[i]); end
      checks++; if (pe[i] !== 1'b0 || fe[i] !== 1'b0) begin
        errors++; $display("FAIL loopback_framing %0d parity_err %b frame_err %b want 0 0", i, pe[i], fe[i]); end
    end
    repeat (40) @(negedge clk_3125);
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, 12'hD4A);
    test_frame(8'h07, 12'hFC0);
    test_frame(8'h00, 12'hC00);
    test_frame(8'h5A, 12'hCB4);
    test_burst();
    test_reset_mid();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
